// File: rtl/ysyx_23060059_scoreboard.sv
// Register/CSR scoreboard: tracks in-flight writes per GPR and CSR and
// stalls decode while any source operand still has a pending write.
module ysyx_23060059_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned NCSR  = 4,
  parameter int unsigned CNT_W = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       id_valid,
  output logic       id_ready,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [1:0] id_csr_rs,
  input  logic       id_csr_used,
  input  logic [4:0] id_rd,
  input  logic       id_reg_en,
  input  logic [1:0] id_csr_rd,
  input  logic       id_csreg_en,
  input  logic       id_ecall,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_en,
  input  logic [1:0] wb_csr_rd,
  input  logic       wb_csreg_en,
  input  logic       wb_ecall,
  input  logic       flush,
  output logic       busy,
  output logic [2:0] inflight,
  output logic       sb_err
);

  localparam int unsigned     INF_W   = 3;
  localparam logic [4:0]      ECALL_RS = 5'd15;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [INF_W-1:0] INF_MAX = INF_W'(DEPTH);

  logic [CNT_W-1:0] gcnt     [NREG];
  logic [CNT_W-1:0] gcnt_nxt [NREG];
  logic [CNT_W-1:0] ccnt     [NCSR];
  logic [CNT_W-1:0] ccnt_nxt [NCSR];
  logic [INF_W-1:0] inflight_nxt;
  logic             err_set;

  logic [NREG-1:0]  g_inc, g_dec;
  logic [NCSR-1:0]  c_inc, c_dec;
  logic             inf_inc, inf_dec;

  logic id_wr_g, id_wr_any, wb_wr_g, wb_wr_any;
  logic gpr_haz, csr_haz, res_blk, issue;

  // Decode-side write classification and hazard / resource checks
  always_comb begin
    id_wr_g   = id_reg_en && (id_rd != 5'd0);
    id_wr_any = id_wr_g || id_csreg_en || id_ecall;
    wb_wr_g   = wb_reg_en && (wb_rd != 5'd0);
    wb_wr_any = wb_wr_g || wb_csreg_en || wb_ecall;

    gpr_haz = (id_rs1_used && (id_rs1 != 5'd0) && (gcnt[id_rs1] != '0)) ||
              (id_rs2_used && (id_rs2 != 5'd0) && (gcnt[id_rs2] != '0)) ||
              (id_ecall && (gcnt[ECALL_RS] != '0));
    csr_haz = id_csr_used && (ccnt[id_csr_rs] != '0);
    res_blk = (id_wr_g && (gcnt[id_rd] == CNT_MAX)) ||
              (id_csreg_en && (ccnt[id_csr_rd] == CNT_MAX)) ||
              (id_ecall && (ccnt[0] == CNT_MAX)) ||
              (id_wr_any && (inflight == INF_MAX));

    id_ready = reset && !flush && !gpr_haz && !csr_haz && !res_blk;
    issue    = id_valid && id_ready;
  end

  // Per-counter increment/decrement requests from issue and retire
  always_comb begin
    g_inc   = '0;
    g_dec   = '0;
    c_inc   = '0;
    c_dec   = '0;
    inf_inc = 1'b0;
    inf_dec = 1'b0;
    if (issue) begin
      if (id_wr_g)     g_inc[id_rd]     = 1'b1;
      if (id_csreg_en) c_inc[id_csr_rd] = 1'b1;
      if (id_ecall)    c_inc[0]         = 1'b1;
      inf_inc = id_wr_any;
    end
    if (wb_valid) begin
      if (wb_wr_g)     g_dec[wb_rd]     = 1'b1;
      if (wb_csreg_en) c_dec[wb_csr_rd] = 1'b1;
      if (wb_ecall)    c_dec[0]         = 1'b1;
      inf_dec = wb_wr_any;
    end
  end

  // Next counter values; retire on an empty counter clamps and flags an error
  always_comb begin
    err_set = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      gcnt_nxt[i] = gcnt[i];
      if (g_dec[i] && (gcnt[i] == '0)) err_set = 1'b1;
      if (g_inc[i] && !(g_dec[i] && (gcnt[i] != '0)))
        gcnt_nxt[i] = gcnt[i] + CNT_W'(1);
      else if (!g_inc[i] && g_dec[i] && (gcnt[i] != '0))
        gcnt_nxt[i] = gcnt[i] - CNT_W'(1);
    end
    for (int i = 0; i < NCSR; i++) begin
      ccnt_nxt[i] = ccnt[i];
      if (c_dec[i] && (ccnt[i] == '0)) err_set = 1'b1;
      if (c_inc[i] && !(c_dec[i] && (ccnt[i] != '0)))
        ccnt_nxt[i] = ccnt[i] + CNT_W'(1);
      else if (!c_inc[i] && c_dec[i] && (ccnt[i] != '0))
        ccnt_nxt[i] = ccnt[i] - CNT_W'(1);
    end
    inflight_nxt = inflight;
    if (inf_dec && (inflight == '0)) err_set = 1'b1;
    if (inf_inc && !(inf_dec && (inflight != '0)))
      inflight_nxt = inflight + INF_W'(1);
    else if (!inf_inc && inf_dec && (inflight != '0))
      inflight_nxt = inflight - INF_W'(1);
    if (flush) begin
      for (int i = 0; i < NREG; i++) gcnt_nxt[i] = '0;
      for (int i = 0; i < NCSR; i++) ccnt_nxt[i] = '0;
      inflight_nxt = '0;
      err_set      = 1'b0;
    end
  end

  // State and registered status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) gcnt[i] <= '0;
      for (int i = 0; i < NCSR; i++) ccnt[i] <= '0;
      inflight <= '0;
      busy     <= 1'b0;
      sb_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) gcnt[i] <= gcnt_nxt[i];
      for (int i = 0; i < NCSR; i++) ccnt[i] <= ccnt_nxt[i];
      inflight <= inflight_nxt;
      busy     <= (inflight_nxt != '0);
      sb_err   <= sb_err || err_set;
    end
  end

endmodule

// File: tb/tb_ysyx_23060059_scoreboard.sv
// Bench for the scoreboard: directed scenarios plus random traffic checked
// against a counting model with an in-order queue of in-flight writers.
module tb_ysyx_23060059_scoreboard;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid, id_ready;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic       id_rs1_used, id_rs2_used, id_csr_used, id_reg_en, id_csreg_en, id_ecall;
  logic [1:0] id_csr_rs, id_csr_rd, wb_csr_rd;
  logic       wb_valid, wb_reg_en, wb_csreg_en, wb_ecall, flush;
  logic       busy, sb_err;
  logic [2:0] inflight;

  ysyx_23060059_scoreboard dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_csr_rs(id_csr_rs), .id_csr_used(id_csr_used),
    .id_rd(id_rd), .id_reg_en(id_reg_en),
    .id_csr_rd(id_csr_rd), .id_csreg_en(id_csreg_en), .id_ecall(id_ecall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_en(wb_reg_en),
    .wb_csr_rd(wb_csr_rd), .wb_csreg_en(wb_csreg_en), .wb_ecall(wb_ecall),
    .flush(flush), .busy(busy), .inflight(inflight), .sb_err(sb_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rd;
    logic       reg_en;
    logic [1:0] csr_rd;
    logic       csreg_en;
    logic       ecall;
  } wr_t;

  int  n_chk = 0;
  int  n_err = 0;
  int  gm [32];
  int  cm [4];
  int  infl;
  bit  merr;
  wr_t q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_clear();
    foreach (gm[i]) gm[i] = 0;
    foreach (cm[i]) cm[i] = 0;
    infl = 0;
  endtask

  // Model: an instruction may issue when no read source is pending and
  // no written target is saturated (counter 3, or 4 writers in flight).
  function automatic bit m_ready();
    bit haz, wr, blk;
    haz = (id_rs1_used && id_rs1 != 0 && gm[id_rs1] != 0) ||
          (id_rs2_used && id_rs2 != 0 && gm[id_rs2] != 0) ||
          (id_ecall && gm[15] != 0) ||
          (id_csr_used && cm[id_csr_rs] != 0);
    wr  = (id_reg_en && id_rd != 0) || id_csreg_en || id_ecall;
    blk = (id_reg_en && id_rd != 0 && gm[id_rd] == 3) ||
          (id_csreg_en && cm[id_csr_rd] == 3) ||
          (id_ecall && cm[0] == 3) || (wr && infl == 4);
    return reset && !flush && !haz && !blk;
  endfunction

  task automatic m_edge(input bit rdy);
    bit [3:0] ct;
    bit       any;
    wr_t      e;
    if (flush) begin
      m_clear();
      return;
    end
    if (wb_valid) begin
      ct = '0;
      if (wb_csreg_en) ct[wb_csr_rd] = 1'b1;
      if (wb_ecall)    ct[0] = 1'b1;
      any = (wb_reg_en && wb_rd != 0) || (ct != 0);
      if (wb_reg_en && wb_rd != 0) begin
        if (gm[wb_rd] == 0) merr = 1; else gm[wb_rd]--;
      end
      for (int i = 0; i < 4; i++)
        if (ct[i]) begin
          if (cm[i] == 0) merr = 1; else cm[i]--;
        end
      if (any) begin
        if (infl == 0) merr = 1; else infl--;
      end
    end
    if (id_valid && rdy) begin
      ct = '0;
      if (id_csreg_en) ct[id_csr_rd] = 1'b1;
      if (id_ecall)    ct[0] = 1'b1;
      any = (id_reg_en && id_rd != 0) || (ct != 0);
      if (id_reg_en && id_rd != 0) gm[id_rd]++;
      for (int i = 0; i < 4; i++) if (ct[i]) cm[i]++;
      if (any) begin
        infl++;
        e.rd = id_rd; e.reg_en = id_reg_en; e.csr_rd = id_csr_rd;
        e.csreg_en = id_csreg_en; e.ecall = id_ecall;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_csr_rs = 0; id_csr_used = 0; id_rd = 0; id_reg_en = 0;
    id_csr_rd = 0; id_csreg_en = 0; id_ecall = 0;
    wb_valid = 0; wb_rd = 0; wb_reg_en = 0; wb_csr_rd = 0;
    wb_csreg_en = 0; wb_ecall = 0; flush = 0;
  endtask

  // Called just after a falling edge with inputs set; ends on the next falling edge
  task automatic step();
    bit rdy;
    #1;
    rdy = m_ready();
    chk("id_ready", 32'(id_ready), 32'(rdy));
    @(posedge clock);
    m_edge(rdy);
    @(negedge clock);
    chk("inflight", 32'(inflight), 32'(infl));
    chk("busy", 32'(busy), 32'(infl != 0));
    chk("sb_err", 32'(sb_err), 32'(merr));
    idle();
  endtask

  task automatic wr_gpr(input logic [4:0] r);
    id_valid = 1; id_reg_en = 1; id_rd = r;
  endtask

  task automatic rt_gpr(input logic [4:0] r);
    wb_valid = 1; wb_reg_en = 1; wb_rd = r;
  endtask

  function automatic logic [4:0] pick();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd15 : 5'(r);
  endfunction

  initial begin
    wr_t e;
    idle();
    m_clear();
    merr = 0;
    repeat (2) @(negedge clock);
    chk("rst_ready", 32'(id_ready), 32'd0);
    chk("rst_infl", 32'(inflight), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(sb_err), 32'd0);
    reset = 1;

    // RAW on x5 released one cycle after its retire
    wr_gpr(5); step();
    chk("x5_infl", 32'(inflight), 32'd1);
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    #1 chk("x5_stall", 32'(id_ready), 32'd0);
    step();
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1; rt_gpr(5);
    #1 chk("x5_no_bypass", 32'(id_ready), 32'd0);
    step();
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    #1 chk("x5_release", 32'(id_ready), 32'd1);
    step();

    // x0 is never tracked
    wr_gpr(0); id_rs1 = 0; id_rs1_used = 1; step();
    chk("x0_infl", 32'(inflight), 32'd0);

    // Depth limit blocks writers but not non-writers
    wr_gpr(3); step(); wr_gpr(4); step(); wr_gpr(6); step(); wr_gpr(7); step();
    chk("full_infl", 32'(inflight), 32'd4);
    wr_gpr(9);
    #1 chk("full_block", 32'(id_ready), 32'd0);
    step();
    id_valid = 1; id_rs1 = 8; id_rs1_used = 1;
    #1 chk("full_branch", 32'(id_ready), 32'd1);
    step();
    rt_gpr(3); step(); rt_gpr(4); step(); rt_gpr(6); step(); rt_gpr(7); step();

    // ecall waits for x15, then csrr mcause waits for the ecall
    wr_gpr(15); step();
    id_valid = 1; id_ecall = 1;
    #1 chk("ecall_stall", 32'(id_ready), 32'd0);
    step();
    id_valid = 1; id_ecall = 1; rt_gpr(15); step();
    id_valid = 1; id_ecall = 1;
    #1 chk("ecall_go", 32'(id_ready), 32'd1);
    step();
    id_valid = 1; id_csr_used = 1; id_csr_rs = 0;
    #1 chk("mcause_stall", 32'(id_ready), 32'd0);
    step();
    id_valid = 1; id_csr_used = 1; wb_valid = 1; wb_ecall = 1; step();
    id_valid = 1; id_csr_used = 1;
    #1 chk("mcause_go", 32'(id_ready), 32'd1);
    step();

    // Same-cycle issue and retire of x9
    wr_gpr(9); step();
    wr_gpr(9); rt_gpr(9); step();
    chk("x9_net", 32'(inflight), 32'd1);
    rt_gpr(9); step();

    // Random traffic, retires taken in order from the model queue
    flush = 1; step(); q.delete();
    for (int n = 0; n < 400; n++) begin
      id_valid    = ($urandom_range(0, 9) < 8);
      id_rs1      = pick(); id_rs1_used = 1'($urandom);
      id_rs2      = pick(); id_rs2_used = 1'($urandom);
      id_csr_rs   = 2'($urandom); id_csr_used = ($urandom_range(0, 3) == 0);
      id_rd       = pick(); id_reg_en = ($urandom_range(0, 2) != 0);
      id_csr_rd   = 2'($urandom); id_csreg_en = ($urandom_range(0, 4) == 0);
      id_ecall    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) begin
        flush = 1;
        q.delete();
      end else if (q.size() != 0 && $urandom_range(0, 2) == 0) begin
        e = q.pop_front();
        wb_valid = 1; wb_rd = e.rd; wb_reg_en = e.reg_en;
        wb_csr_rd = e.csr_rd; wb_csreg_en = e.csreg_en; wb_ecall = e.ecall;
      end
      step();
    end
    flush = 1; step(); q.delete();

    // Orphan retire sets sticky error; flush clears counts but not the error
    rt_gpr(12); step();
    chk("orphan_err", 32'(sb_err), 32'd1);
    wr_gpr(1); step(); wr_gpr(2); step(); wr_gpr(3); step();
    chk("pre_flush", 32'(inflight), 32'd3);
    flush = 1; step(); q.delete();
    chk("flush_infl", 32'(inflight), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_err", 32'(sb_err), 32'd1);

    // Asynchronous reset in mid-cycle
    wr_gpr(20); step();
    #2 reset = 0;
    #1;
    chk("arst_infl", 32'(inflight), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(sb_err), 32'd0);
    chk("arst_ready", 32'(id_ready), 32'd0);
    m_clear(); merr = 0; q.delete();
    @(negedge clock);
    reset = 1;
    id_valid = 1; id_rs1 = 20; id_rs1_used = 1; step();
    wr_gpr(20); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
